obsidian_fetch_stage: RTL

Instruction-fetch stage of the Obsidian LEGv8 pipeline: the producer of the 64-bit `IF_ID` word that the decode stage consumes. It holds the PC, reads a word-addressed instruction memory, and registers `{PC, instruction}` into `IF_ID` each cycle. It also handles stall hold, branch redirect from the branch-resolution stage, and a halt state.

---
 rtl/obsidian_pkg.sv | 31 +++
 rtl/obsidian_imem.sv | 28 ++
 rtl/obsidian_fetch_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/obsidian_pkg.sv
// Shared definitions for the Obsidian fetch stage: IF_ID field layout,
// special instruction words and the fetch FSM state encoding.
package obsidian_pkg;

  // IF_ID field offsets: PC in the upper half, instruction in the lower half
  localparam int IFID_PC_MSB   = 63;
  localparam int IFID_PC_LSB   = 32;
  localparam int IFID_INSN_MSB = 31;
  localparam int IFID_INSN_LSB = 0;

  // Opcode 0 decodes as a no-op, so an all-zero word is a safe bubble
  localparam logic [31:0] BUBBLE    = 32'h0000_0000;
  // Fetching this word stops the stage until a redirect arrives
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // Build an IF_ID word from its two fields
  function automatic logic [63:0] pack_if_id(input logic [31:0] pc,
                                             input logic [31:0] insn);
    logic [63:0] w;
    w = '0;
    w[IFID_PC_MSB:IFID_PC_LSB]     = pc;
    w[IFID_INSN_MSB:IFID_INSN_LSB] = insn;
    return w;
  endfunction

endpackage

// File: rtl/obsidian_imem.sv
// Word-addressed instruction memory: combinational read port, synchronous
// write port. A write and a read of the same word on one edge return the
// old contents because the array only changes at the clock edge.
// Contents are deliberately not reset.
module obsidian_imem #(
  parameter int WORDS = 256,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  // Load port: one word per edge when the strobe is high
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/obsidian_fetch_stage.sv
// Instruction-fetch stage of the Obsidian LEGv8 pipeline. Holds the PC,
// reads obsidian_imem and registers {PC, instruction} into IF_ID.
// Optional feature macro: OBSIDIAN_FETCH_PERF_EN adds fetch_count and
// bubble_count performance counters.
//
// Flow control: there is no valid/ready pair toward decode. if_valid marks
// IF_ID as a real instruction (1) or a bubble (0); stall high on an edge
// holds IF_ID, if_valid and pc, while branch_taken overrides stall and
// HALT, flushing the wrong-path word by overwriting IF_ID with the target.
// The FSM state is observable directly on halted (state == HALT).
module obsidian_fetch_stage
  import obsidian_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [63:0] IF_ID,
  output logic        if_valid,
  output logic        halted
`ifdef OBSIDIAN_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  localparam int IDX_W = $clog2(IMEM_WORDS);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [63:0]  if_id_q, if_id_d;
  logic         valid_q, valid_d;
  logic         fetch_inc;

  logic [31:0]  tgt;
  logic [31:0]  fetch_addr;
  logic [31:0]  fetch_word;
  logic         word_is_halt;
  logic         unused_bits;

  // Redirect target is word aligned; the low two bits are dropped
  assign tgt = {branch_target[31:2], 2'b00};

  // A redirect fetches its target on the same edge, so the memory is read
  // at the target instead of the current pc whenever branch_taken is high
  assign fetch_addr   = branch_taken ? tgt : pc_q;
  assign word_is_halt = (fetch_word == HALT_WORD);

  // Address bits outside the memory index are intentionally ignored
  assign unused_bits = ^{imem_waddr[31:IDX_W+2], imem_waddr[1:0],
                         fetch_addr[31:IDX_W+2], fetch_addr[1:0],
                         branch_target[1:0]};

  obsidian_imem #(
    .WORDS (IMEM_WORDS),
    .IDX_W (IDX_W)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr[IDX_W+1:2]),
    .wdata (imem_wdata),
    .raddr (fetch_addr[IDX_W+1:2]),
    .rdata (fetch_word)
  );

  // Next-state and next-output selection in priority order:
  // redirect, HALT hold, stall hold, halt-word bubble, normal fetch
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_id_d   = if_id_q;
    valid_d   = valid_q;
    fetch_inc = 1'b0;
    if (branch_taken) begin
      if (word_is_halt) begin
        if_id_d = pack_if_id(tgt, BUBBLE);
        valid_d = 1'b0;
        pc_d    = tgt;
        state_d = ST_HALT;
      end else begin
        if_id_d   = pack_if_id(tgt, fetch_word);
        valid_d   = 1'b1;
        pc_d      = tgt + 32'd4;
        state_d   = ST_RUN;
        fetch_inc = 1'b1;
      end
    end else if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (stall) begin
      state_d = ST_RUN;
    end else if (word_is_halt) begin
      if_id_d = pack_if_id(pc_q, BUBBLE);
      valid_d = 1'b0;
      state_d = ST_HALT;
    end else begin
      if_id_d   = pack_if_id(pc_q, fetch_word);
      valid_d   = 1'b1;
      pc_d      = pc_q + 32'd4;
      fetch_inc = 1'b1;
    end
  end

  // Pipeline register, PC and FSM state; reset aborts everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      if_id_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      valid_q <= valid_d;
    end
  end

`ifdef OBSIDIAN_FETCH_PERF_EN
  // Every edge out of reset either delivers an instruction or is a bubble
  // (stall, HALT hold, or halt-word bubble), so the two counters partition edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else if (fetch_inc) begin
      fetch_count  <= fetch_count + 32'd1;
    end else begin
      bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

  assign IF_ID    = if_id_q;
  assign if_valid = valid_q;
  assign halted   = (state_q == ST_HALT);

endmodule
